// File: rtl/fifo_mc_pkg.sv
// Shared constants for the multi-channel FIFO: default geometry, per-channel depth,
// channel-select width and occupancy-count width.
package fifo_mc_pkg;

    localparam int DATA_SIZE_DEF = 6;
    localparam int ADDR_SIZE_DEF = 3;
    localparam int NUM_CH_DEF    = 4;

    // A single channel still needs a one-bit select so the ports never collapse to zero width.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEPTH = 2 ** ADDR_SIZE_DEF;
    localparam int CH_W  = ch_width(NUM_CH_DEF);
    localparam int CNT_W = ADDR_SIZE_DEF + 1;

endpackage

// File: rtl/fifo_ram.sv
// Shared word storage for all channels, addressed {channel, pointer}. It has one write
// port and one synchronous read port whose output register holds between reads.
module fifo_ram
    import fifo_mc_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_W    = CH_W + ADDR_SIZE_DEF,
    parameter int WORDS     = NUM_CH_DEF * DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    logic [DATA_SIZE-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is cleared; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO: NUM_CH independent queues sharing one RAM, with per-channel
// status flags, a hysteresis pause output and a sticky overflow/underflow error.
module fifo_mc
    import fifo_mc_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    localparam int CH_BITS  = ch_width(NUM_CH),
    localparam int CNT_BITS = ADDR_SIZE + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [CH_BITS-1:0]   push_ch,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    input  logic [CH_BITS-1:0]   pop_ch,
    input  logic [CNT_BITS-1:0]  umb_almost_full,
    input  logic [CNT_BITS-1:0]  umb_almost_empty,
    input  logic                 err_clr,
    output logic [DATA_SIZE-1:0] pop_data,
    output logic                 pop_valid,
    output logic [NUM_CH-1:0]    empty,
    output logic [NUM_CH-1:0]    full,
    output logic [NUM_CH-1:0]    almost_full,
    output logic [NUM_CH-1:0]    almost_empty,
    output logic                 pause,
    output logic                 error
);

    localparam int WORDS = NUM_CH * (2 ** ADDR_SIZE);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(2 ** ADDR_SIZE);

    logic [ADDR_SIZE-1:0] wr_ptr     [NUM_CH];
    logic [ADDR_SIZE-1:0] rd_ptr     [NUM_CH];
    logic [CNT_BITS-1:0]  count      [NUM_CH];
    logic [CNT_BITS-1:0]  count_next [NUM_CH];
    logic [NUM_CH-1:0]    pause_r;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 fault;

    always_comb begin
        empty        = '0;
        full         = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            empty[i]        = (count[i] == '0);
            full[i]         = (count[i] == DEPTH_CNT);
            almost_full[i]  = (count[i] >= umb_almost_full);
            almost_empty[i] = (count[i] <= umb_almost_empty);
        end
    end

    // Acceptance looks only at registered counts, so a pop of an empty channel is
    // refused even when the same channel is being pushed this cycle.
    always_comb begin
        push_ok = push && (int'(push_ch) < NUM_CH) && !full[push_ch];
        pop_ok  = pop && (int'(pop_ch) < NUM_CH) && !empty[pop_ch];
        fault   = (push && !push_ok) || (pop && !pop_ok);
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_next[i] = count[i];
            if (push_ok && int'(push_ch) == i && !(pop_ok && int'(pop_ch) == i)) begin
                count_next[i] = count[i] + 1'b1;
            end else if (pop_ok && int'(pop_ch) == i && !(push_ok && int'(push_ch) == i)) begin
                count_next[i] = count[i] - 1'b1;
            end
        end
    end

    // Pause is evaluated on the post-update count so it lines up with the count it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            pause_r   <= '0;
            pop_valid <= 1'b0;
            error     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count[i] <= count_next[i];
                if (count_next[i] >= umb_almost_full) begin
                    pause_r[i] <= 1'b1;
                end else if (count_next[i] <= umb_almost_empty) begin
                    pause_r[i] <= 1'b0;
                end
            end
            if (push_ok) begin
                wr_ptr[push_ch] <= wr_ptr[push_ch] + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr[pop_ch] <= rd_ptr[pop_ch] + 1'b1;
            end
            pop_valid <= pop_ok;
            if (fault) begin
                error <= 1'b1;
            end else if (err_clr) begin
                error <= 1'b0;
            end
        end
    end

    assign pause = |pause_r;

    fifo_ram #(
        .DATA_SIZE(DATA_SIZE),
        .ADDR_W   (CH_BITS + ADDR_SIZE),
        .WORDS    (WORDS)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (push_ok && !reset),
        .waddr({push_ch, wr_ptr[push_ch]}),
        .wdata(push_data),
        .re   (pop_ok && !reset),
        .raddr({pop_ch, rd_ptr[pop_ch]}),
        .rdata(pop_data)
    );

endmodule
